gate_window_ctrl: RTL and testbench

//   Sequences frequency measurement by running a repeating gate window of programmable length.

---
 rtl/gate_window_if.sv | 27 ++
 rtl/gate_window_ctrl.sv | 95 +++++++++
 tb/tb_gate_window_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_window_if.sv
// Bundles the gate-window controller's control inputs and its published window results.
// Handshake: count_valid is a one-cycle strobe with no ready/backpressure; count_out and
// overflow are stable from that strobe until the next one, so a consumer may sample them at any time.
interface gate_window_if #(
  parameter int COUNT_W  = 12,
  parameter int PERIOD_W = 16
);
  logic                enable;
  logic                period_load;
  logic [PERIOD_W-1:0] period_in;
  logic                edge_in;
  logic                gate_active;
  logic [COUNT_W-1:0]  count_out;
  logic                count_valid;
  logic                overflow;
  logic                state_dbg;

  modport master (
    output enable, period_load, period_in, edge_in,
    input  gate_active, count_out, count_valid, overflow, state_dbg
  );

  modport slave (
    input  enable, period_load, period_in, edge_in,
    output gate_active, count_out, count_valid, overflow, state_dbg
  );
endinterface

// File: rtl/gate_window_ctrl.sv
// Repeating gate window of programmable length; counts edge pulses per window and
// publishes each completed window's total with a one-cycle strobe.
module gate_window_ctrl #(
  parameter int COUNT_W        = 12,
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic           clk,
  input  logic           reset,
  gate_window_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  state_t              state;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] timer;
  logic [COUNT_W-1:0]  edge_cnt;
  logic                ovf_flag;
  logic                gate_active;
  logic [COUNT_W-1:0]  count_out;
  logic                count_valid;
  logic                overflow;

  logic               at_sat;
  logic               inc_ovf;
  logic [COUNT_W-1:0] next_cnt;

  // Saturating accumulate of this cycle's edge; a lost increment marks the window overflowed.
  always_comb begin
    at_sat   = (edge_cnt == CNT_MAX);
    inc_ovf  = bus.edge_in & at_sat;
    next_cnt = edge_cnt;
    if (bus.edge_in && !at_sat) next_cnt = edge_cnt + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      period_reg  <= PERIOD_W'(DEFAULT_PERIOD);
      timer       <= '0;
      edge_cnt    <= '0;
      ovf_flag    <= 1'b0;
      gate_active <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (bus.period_load)
        period_reg <= (bus.period_in == '0) ? PERIOD_W'(1) : bus.period_in;

      case (state)
        IDLE: begin
          edge_cnt <= '0;
          ovf_flag <= 1'b0;
          if (bus.enable) begin
            state       <= COUNT;
            gate_active <= 1'b1;
            timer       <= period_reg - PERIOD_W'(1);
          end
        end
        COUNT: begin
          if (!bus.enable) begin
            // Abort discards the partial window; published results stay as they were.
            state       <= IDLE;
            gate_active <= 1'b0;
            edge_cnt    <= '0;
            ovf_flag    <= 1'b0;
          end else if (timer == '0) begin
            // Reload reads period_reg before any same-cycle load lands.
            count_out   <= next_cnt;
            overflow    <= ovf_flag | inc_ovf;
            count_valid <= 1'b1;
            timer       <= period_reg - PERIOD_W'(1);
            edge_cnt    <= '0;
            ovf_flag    <= 1'b0;
          end else begin
            timer    <= timer - PERIOD_W'(1);
            edge_cnt <= next_cnt;
            ovf_flag <= ovf_flag | inc_ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gate_active = gate_active;
  assign bus.count_out   = count_out;
  assign bus.count_valid = count_valid;
  assign bus.overflow    = overflow;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_gate_window_ctrl.sv
// Directed bench for gate_window_ctrl: a per-cycle vector table plus hand-written
// sequences for window timing, edge accounting, saturation, abort and reset.
module tb_gate_window_ctrl;
  logic clk = 1'b0;
  logic reset;

  // Clock/reset
  always #5 clk = ~clk;

  gate_window_if #(.COUNT_W(12), .PERIOD_W(16)) a ();
  gate_window_if #(.COUNT_W(4),  .PERIOD_W(16)) b ();

  gate_window_ctrl #(.COUNT_W(12), .PERIOD_W(16), .DEFAULT_PERIOD(1000)) dut_a (
    .clk(clk), .reset(reset), .bus(a.slave)
  );
  gate_window_ctrl #(.COUNT_W(4), .PERIOD_W(16), .DEFAULT_PERIOD(20)) dut_b (
    .clk(clk), .reset(reset), .bus(b.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected published totals for dut_a
  logic [11:0] exp_q[$];
  logic        sb_on = 1'b0;

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] pin;
    logic        e;
    logic        g;
    logic        v;
    logic [11:0] c;
    logic        o;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input int en, ld, pin, e, g, v, c, o);
    vec_t r;
    r.en = 1'(en); r.ld = 1'(ld); r.pin = 16'(pin); r.e = 1'(e);
    r.g = 1'(g); r.v = 1'(v); r.c = 12'(c); r.o = 1'(o);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_a(input logic en, input logic ld, input logic [15:0] pin, input logic e);
    a.enable = en; a.period_load = ld; a.period_in = pin; a.edge_in = e;
  endtask

  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (sb_on && a.count_valid) begin
      if (exp_q.size() == 0) chk("sb_unexpected_strobe", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_count", 32'(a.count_out), 32'(e));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_a(1'b0, 1'b0, 16'd0, 1'b0);
    b.enable = 1'b0; b.period_load = 1'b0; b.period_in = '0; b.edge_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic sb_drain(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 3, 0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1,  1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1,  1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0,  1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 1,  1, 1, 2, 0);
    tbl[5]  = mk(1, 0, 0, 1,  1, 0, 2, 0);
    tbl[6]  = mk(1, 0, 0, 1,  1, 0, 2, 0);
    tbl[7]  = mk(1, 1, 0, 1,  1, 1, 3, 0);
    tbl[8]  = mk(1, 0, 0, 0,  1, 0, 3, 0);
    tbl[9]  = mk(1, 0, 0, 0,  1, 0, 3, 0);
    tbl[10] = mk(1, 0, 0, 1,  1, 1, 1, 0);
    tbl[11] = mk(1, 0, 0, 0,  1, 1, 0, 0);
    tbl[12] = mk(1, 0, 0, 1,  1, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 1,  0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0,  0, 0, 1, 0);

    // Reset state
    do_reset();
    chk("rst_gate",  32'(a.gate_active), 32'd0);
    chk("rst_count", 32'(a.count_out),   32'd0);
    chk("rst_valid", 32'(a.count_valid), 32'd0);
    chk("rst_ovf",   32'(a.overflow),    32'd0);
    chk("rst_state", 32'(a.state_dbg),   32'd0);
    chk("rst_b_count", 32'(b.count_out), 32'd0);

    // Default period: one 1000-cycle window, edge every 3rd cycle
    sb_on = 1'b1;
    exp_q.push_back(12'd333);
    drive_a(1'b1, 1'b0, 16'd0, 1'b0);
    step();
    chk("t0_gate_entry", 32'(a.gate_active), 32'd1);
    for (int k = 1; k <= 1000; k++) begin
      drive_a(1'b1, 1'b0, 16'd0, (k % 3) == 0);
      step();
    end
    chk("t0_valid_at_1000", 32'(a.count_valid), 32'd1);
    sb_drain("t0_drain");
    sb_on = 1'b0;

    // Vector table: period 3, load at terminal cycle, period 0 -> 1, abort
    do_reset();
    foreach (tbl[i]) begin
      drive_a(tbl[i].en, tbl[i].ld, tbl[i].pin, tbl[i].e);
      step();
      chk($sformatf("tbl%0d_gate", i),  32'(a.gate_active), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_valid", i), 32'(a.count_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_count", i), 32'(a.count_out),   32'(tbl[i].c));
      chk($sformatf("tbl%0d_ovf", i),   32'(a.overflow),    32'(tbl[i].o));
    end

    // Period 10, edge every 2nd cycle
    do_reset();
    drive_a(1'b0, 1'b1, 16'd10, 1'b0);
    step();
    sb_on = 1'b1;
    repeat (3) exp_q.push_back(12'd5);
    drive_a(1'b1, 1'b0, 16'd0, 1'b0);
    step();
    for (int k = 1; k <= 30; k++) begin
      drive_a(1'b1, 1'b0, 16'd0, (k % 2) == 1);
      step();
      chk($sformatf("t1_valid_k%0d", k), 32'(a.count_valid), 32'((k % 10) == 0));
    end
    chk("t1_ovf", 32'(a.overflow), 32'd0);
    sb_drain("t1_drain");

    // Period 8, edges on terminal cycle and first cycle of next window
    drive_a(1'b0, 1'b1, 16'd8, 1'b0);
    step();
    exp_q.push_back(12'd1);
    exp_q.push_back(12'd1);
    exp_q.push_back(12'd0);
    drive_a(1'b1, 1'b0, 16'd0, 1'b0);
    step();
    for (int k = 1; k <= 24; k++) begin
      drive_a(1'b1, 1'b0, 16'd0, (k == 8) || (k == 9));
      step();
      chk($sformatf("t2_valid_k%0d", k), 32'(a.count_valid), 32'((k % 8) == 0));
    end
    sb_drain("t2_drain");
    sb_on = 1'b0;
    drive_a(1'b0, 1'b0, 16'd0, 1'b0);

    // Saturation on the 4-bit instance, period 20
    b.enable = 1'b1;
    step();
    for (int k = 1; k <= 40; k++) begin
      b.edge_in = (k <= 23);
      step();
      if (k == 20) begin
        chk("t3_sat_valid", 32'(b.count_valid), 32'd1);
        chk("t3_sat_count", 32'(b.count_out),   32'd15);
        chk("t3_sat_ovf",   32'(b.overflow),    32'd1);
      end
      if (k == 39) chk("t3_no_early_strobe", 32'(b.count_valid), 32'd0);
      if (k == 40) begin
        chk("t3_next_valid", 32'(b.count_valid), 32'd1);
        chk("t3_next_count", 32'(b.count_out),   32'd3);
        chk("t3_next_ovf",   32'(b.overflow),    32'd0);
      end
    end
    b.enable = 1'b0;
    b.edge_in = 1'b0;

    // Period reload mid-window (10 -> 4), then period_in=0
    do_reset();
    drive_a(1'b0, 1'b1, 16'd10, 1'b0);
    step();
    drive_a(1'b1, 1'b0, 16'd0, 1'b0);
    step();
    for (int k = 1; k <= 26; k++) begin
      drive_a(1'b1, (k == 3) || (k == 19), (k == 3) ? 16'd4 : 16'd0, 1'b0);
      step();
      chk($sformatf("t4_valid_k%0d", k), 32'(a.count_valid),
          32'((k == 10) || (k == 14) || (k == 18) || (k >= 22)));
    end

    // Abort mid-window, then restart for a full window
    do_reset();
    drive_a(1'b0, 1'b1, 16'd10, 1'b0);
    step();
    sb_on = 1'b1;
    exp_q.push_back(12'd10);
    drive_a(1'b1, 1'b0, 16'd0, 1'b0);
    step();
    for (int k = 1; k <= 15; k++) begin
      drive_a(k != 15, 1'b0, 16'd0, 1'b1);
      step();
    end
    chk("t5_abort_gate",  32'(a.gate_active), 32'd0);
    chk("t5_abort_valid", 32'(a.count_valid), 32'd0);
    chk("t5_abort_count", 32'(a.count_out),   32'd10);
    repeat (3) begin
      drive_a(1'b0, 1'b0, 16'd0, 1'b1);
      step();
    end
    chk("t5_idle_count", 32'(a.count_out), 32'd10);
    chk("t5_idle_state", 32'(a.state_dbg), 32'd0);
    exp_q.push_back(12'd3);
    drive_a(1'b1, 1'b0, 16'd0, 1'b0);
    step();
    for (int k = 1; k <= 10; k++) begin
      drive_a(1'b1, 1'b0, 16'd0, k <= 3);
      step();
      chk($sformatf("t5_restart_valid_k%0d", k), 32'(a.count_valid), 32'(k == 10));
    end
    sb_drain("t5_drain");

    // Reset mid-window after a nonzero publish
    drive_a(1'b0, 1'b1, 16'd4, 1'b0);
    step();
    exp_q.push_back(12'd4);
    drive_a(1'b1, 1'b0, 16'd0, 1'b0);
    step();
    for (int k = 1; k <= 6; k++) begin
      drive_a(1'b1, 1'b0, 16'd0, 1'b1);
      step();
    end
    sb_drain("t6_pre_drain");
    reset = 1'b1;
    step();
    chk("t6_gate",  32'(a.gate_active), 32'd0);
    chk("t6_count", 32'(a.count_out),   32'd0);
    chk("t6_valid", 32'(a.count_valid), 32'd0);
    chk("t6_ovf",   32'(a.overflow),    32'd0);
    chk("t6_state", 32'(a.state_dbg),   32'd0);
    reset = 1'b0;
    drive_a(1'b0, 1'b0, 16'd0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("t6_quiet_k%0d", k), 32'(a.count_valid), 32'd0);
    end
    sb_on = 1'b0;

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
